// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the RV32I fetch sequencer: widths, reset PC and
// the fetch FSM encoding.
package fetch_sequencer_pkg;
  localparam int XLEN_DEF = 32;
  localparam int INSN_BYTES = 4;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/fetch_sequencer_fifo.sv
// Small synchronous FIFO with flush; holds in-flight fetch PCs and buffered
// {pc,instruction} pairs. rdata reads as zero while empty.
module fetch_fifo
  import fetch_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = cnt_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = (count == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: rdata is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// RV32I fetch sequencer: owns the fetch PC, issues imem requests, buffers
// returned words for decode and squashes wrong-path fetches on redirect.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int              MAX_OUTST = 2,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            busy
);
  localparam int OW = cnt_w(MAX_OUTST);
  localparam int BW = cnt_w(BUF_DEPTH);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outst, outst_n, drop_cnt, drop_n, pc_count;
  logic [BW-1:0]   buf_count, buf_n;
  logic            fire, buf_push, buf_pop, can_issue;
  logic [XLEN-1:0] rsp_pc;
  logic [2*XLEN-1:0] buf_head;

  assign fire     = imem_req_valid && imem_req_ready;
  assign buf_pop  = inst_valid && inst_ready;
  // A response arriving with a redirect belongs to the old path.
  assign buf_push = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

  assign imem_req_addr = fetch_pc;
  assign inst_valid    = (buf_count != '0);
  assign inst_pc       = buf_head[2*XLEN-1:XLEN];
  assign inst_data     = buf_head[XLEN-1:0];
  assign busy          = (outst != '0) || (buf_count != '0);

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_pc_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fire),
    .wdata (fetch_pc),
    .pop   (imem_rsp_valid),
    .flush (1'b0),
    .rdata (rsp_pc),
    .count (pc_count)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(BUF_DEPTH)) u_inst_buf (
    .clk   (clk),
    .reset (reset),
    .push  (buf_push),
    .wdata ({rsp_pc, imem_rsp_data}),
    .pop   (buf_pop),
    .flush (redirect_valid),
    .rdata (buf_head),
    .count (buf_count)
  );

  // Issue decision is made on next-cycle occupancy so valid is registered
  // and every fired request is guaranteed a buffer slot.
  always_comb begin
    outst_n = outst + OW'(fire) - OW'(imem_rsp_valid);
    buf_n   = redirect_valid ? '0 : buf_count + BW'(buf_push) - BW'(buf_pop);
    if (redirect_valid)
      drop_n = outst_n;
    else if (imem_rsp_valid && (drop_cnt != '0))
      drop_n = drop_cnt - OW'(1);
    else
      drop_n = drop_cnt;
    can_issue = !redirect_valid
             && ((int'(outst_n) + int'(buf_n)) < BUF_DEPTH)
             && (int'(outst_n) < MAX_OUTST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= BOOT;
      fetch_pc       <= RESET_PC;
      outst          <= '0;
      drop_cnt       <= '0;
      imem_req_valid <= 1'b0;
    end else begin
      outst          <= outst_n;
      drop_cnt       <= drop_n;
      imem_req_valid <= 1'b0;
      if (redirect_valid)
        fetch_pc <= {redirect_target[XLEN-1:2], 2'b00};
      else if (fire)
        fetch_pc <= fetch_pc + XLEN'(INSN_BYTES);
      if (redirect_valid) begin
        state <= (outst_n != '0) ? FLUSH : RUN;
      end else begin
        unique case (state)
          BOOT: begin
            state          <= RUN;
            imem_req_valid <= can_issue;
          end
          RUN: imem_req_valid <= can_issue;
          FLUSH: begin
            if (drop_n == '0) begin
              state          <= RUN;
              imem_req_valid <= can_issue;
            end
          end
          default: state <= BOOT;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      assert (!(fire && !imem_rsp_valid && (outst == OW'(MAX_OUTST))));
      assert (!(imem_rsp_valid && (outst == '0)));
      assert (!(buf_push && !buf_pop && (buf_count == BW'(BUF_DEPTH))));
      assert (outst == pc_count);
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_fetch_sequencer;
  localparam int MO = 2;
  localparam int BD = 2;
  localparam int M_BOOT = 0, M_RUN = 1, M_FLUSH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        busy;

  always #5 clk = ~clk;

  fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0), .MAX_OUTST(MO), .BUF_DEPTH(BD)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .busy(busy)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // imem responder (stimulus side) and logs
  typedef struct { logic [31:0] addr; int due; } rq_t;
  rq_t         rq[$];
  logic [31:0] fire_log[$];
  logic [63:0] dlog[$];
  int lat = 1, cyc_n = 0;
  int auto_mode = 0, snap_f = 0, redir_dlog = 0;
  bit auto_hit = 0;
  logic [31:0] auto_tgt = '0, snap0 = '0, snap1 = '0;

  // reference model
  int          m_mode, m_drop;
  bit          m_block, chk_en = 0;
  logic [31:0] m_pc;
  logic [31:0] m_inf[$];
  logic [63:0] m_buf[$];

  task automatic model_reset();
    m_mode = M_BOOT; m_pc = 32'h0; m_drop = 0; m_block = 0;
    m_inf.delete(); m_buf.delete();
  endtask

  task automatic check_and_step();
    logic        e_rv, fire, pop;
    logic [63:0] head;
    logic [31:0] a;
    e_rv = (m_mode == M_RUN) && !m_block && (m_inf.size() + m_buf.size() < BD)
           && (m_inf.size() < MO);
    chk("req_valid", imem_req_valid, e_rv);
    chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", inst_valid, m_buf.size() != 0);
    chk("busy", busy, (m_inf.size() != 0) || (m_buf.size() != 0));
    if (m_buf.size() != 0) begin
      head = m_buf[0];
      chk("inst_pc", inst_pc, head[63:32]);
      chk("inst_data", inst_data, head[31:0]);
    end
    if (inst_valid && inst_ready) dlog.push_back({inst_pc, inst_data});
    if (redirect_valid) redir_dlog = dlog.size();
    fire = e_rv && imem_req_ready;
    pop  = (m_buf.size() != 0) && inst_ready;
    if (pop) void'(m_buf.pop_front());
    if (imem_rsp_valid && m_inf.size() != 0) begin
      a = m_inf.pop_front();
      if (m_drop > 0) m_drop--;
      else if (!redirect_valid) m_buf.push_back({a, imem_rsp_data});
    end
    if (fire) begin
      m_inf.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    m_block = redirect_valid;
    if (redirect_valid) begin
      m_pc = {redirect_target[31:2], 2'b00};
      m_buf.delete();
      m_drop = m_inf.size();
      m_mode = (m_drop > 0) ? M_FLUSH : M_RUN;
    end else if (m_mode == M_BOOT) m_mode = M_RUN;
    else if (m_mode == M_FLUSH && m_drop == 0) m_mode = M_RUN;
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (chk_en) check_and_step();
  end

  // One cycle of stimulus, applied at the negedge; outputs are all registered.
  task automatic cyc(input bit rdy, input bit irdy, input bit redir, input logic [31:0] tgt);
    bit rsp, fire;
    @(negedge clk);
    rsp  = (rq.size() > 0) && (rq[0].due <= cyc_n);
    fire = imem_req_valid && rdy;
    imem_req_ready = rdy; inst_ready = irdy;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    if (rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data_of(rq[0].addr);
      void'(rq.pop_front());
    end
    if (fire) begin
      rq.push_back('{imem_req_addr, cyc_n + lat});
      fire_log.push_back(imem_req_addr);
    end
    if (auto_mode == 1 && fire && rsp) begin
      redir = 1'b1; tgt = auto_tgt; auto_mode = 0; auto_hit = 1;
    end else if (auto_mode == 2 && rq.size() == 2 && !rsp && !fire) begin
      snap0 = rq[0].addr; snap1 = rq[1].addr;
      redir = 1'b1; tgt = auto_tgt; auto_mode = 0; auto_hit = 1;
    end
    if (redir) snap_f = fire_log.size();
    redirect_valid = redir; redirect_target = tgt;
    cyc_n++;
  endtask

  task automatic chk_fire(input string nm, input int idx, input logic [31:0] exp);
    if (idx < fire_log.size()) chk(nm, fire_log[idx], exp);
    else chk({nm, "_count"}, fire_log.size(), idx + 1);
  endtask

  task automatic chk_dlv(input string nm, input int idx, input logic [31:0] pc);
    logic [63:0] e;
    if (idx < dlog.size()) begin
      e = dlog[idx];
      chk({nm, "_pc"}, e[63:32], pc);
      chk({nm, "_data"}, e[31:0], data_of(pc));
    end else chk({nm, "_count"}, dlog.size(), idx + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
    chk({tag, "_inst_valid"}, inst_valid, 1'b0);
    chk({tag, "_inst_data"}, inst_data, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic run_auto(input int mode, input logic [31:0] tgt);
    auto_mode = mode; auto_tgt = tgt; auto_hit = 0;
    for (int i = 0; i < 40 && !auto_hit; i++) cyc(1, 1, 0, 32'h0);
    chk("auto_trigger_hit", auto_hit, 1'b1);
    auto_mode = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, d0, f, d, st;
    logic [31:0] a0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect_valid = 0; redirect_target = '0; inst_ready = 0;
    model_reset();
    #1 check_reset_outputs("reset");
    cyc(0, 1, 0, 32'h0);
    reset = 1'b1; chk_en = 1;

    // 1: streaming fetch from RESET_PC
    lat = 1;
    repeat (12) cyc(1, 1, 0, 32'h0);
    chk_fire("t1_addr0", 0, 32'h0);
    chk_fire("t1_addr1", 1, 32'h4);
    chk_fire("t1_addr2", 2, 32'h8);
    chk("t1_d0_data", dlog.size() > 0 ? dlog[0][31:0] : 32'hx, 32'hDEAD_0000);
    chk("t1_d1_data", dlog.size() > 1 ? dlog[1][31:0] : 32'hx, 32'hDEAD_0004);
    chk_dlv("t1_d2", 2, 32'h8);

    // 2: decode stalls, buffer fills, then drains in order
    f0 = fire_log.size(); d0 = dlog.size();
    repeat (10) cyc(1, 0, 0, 32'h0);
    chk("t2_fires_le2", (fire_log.size() - f0) <= 2, 1'b1);
    chk("t2_req_valid_full", imem_req_valid, 1'b0);
    chk("t2_inst_valid_full", inst_valid, 1'b1);
    repeat (10) cyc(1, 1, 0, 32'h0);
    st = (d0 > 0) ? d0 - 1 : 0;
    for (int i = st; i + 1 < dlog.size(); i++)
      chk_dlv("t2_order", i + 1, dlog[i][63:32] + 32'd4);

    // 3: redirect with two outstanding requests
    lat = 3;
    cyc(1, 1, 1, 32'h10);
    for (int i = 0; i < 20 && !(fire_log.size() > 0 && fire_log[fire_log.size()-1] == 32'h10); i++)
      cyc(1, 1, 0, 32'h0);
    run_auto(2, 32'h100);
    chk("t3_outst0", snap0, 32'h10);
    chk("t3_outst1", snap1, 32'h14);
    cyc(1, 1, 0, 32'h0);
    chk("t3_flush_req_valid", imem_req_valid, 1'b0);
    chk("t3_flush_busy", busy, 1'b1);
    repeat (15) cyc(1, 1, 0, 32'h0);
    chk_fire("t3_next_addr", snap_f, 32'h100);
    chk_dlv("t3_first_inst", redir_dlog, 32'h100);

    // 4: redirect coincident with fire and response, unaligned target
    lat = 1;
    run_auto(1, 32'h203);
    repeat (10) cyc(1, 1, 0, 32'h0);
    chk_fire("t4_next_addr", snap_f, 32'h200);
    chk_dlv("t4_first_inst", redir_dlog, 32'h200);
    chk_dlv("t4_second_inst", redir_dlog + 1, 32'h204);

    // 5: backpressure holds the request; PC wraps
    repeat (3) cyc(0, 1, 0, 32'h0);
    a0 = fire_log[fire_log.size()-1] + 32'd4;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", imem_req_valid, 1'b1);
      chk("t5_hold_addr", imem_req_addr, a0);
      cyc(0, 1, 0, 32'h0);
    end
    cyc(1, 1, 1, 32'hFFFF_FFFC);
    f = fire_log.size();
    repeat (10) cyc(1, 1, 0, 32'h0);
    chk_fire("t5_wrap0", f, 32'hFFFF_FFFC);
    chk_fire("t5_wrap1", f + 1, 32'h0);
    chk_fire("t5_wrap2", f + 2, 32'h4);
    chk_dlv("t5_inst_wrap", redir_dlog + 1, 32'h0);

    // 6: reset while flushing
    lat = 4;
    repeat (3) cyc(1, 1, 0, 32'h0);
    cyc(1, 1, 1, 32'h300);
    cyc(1, 1, 0, 32'h0);
    chk("t6_flush_busy", busy, 1'b1);
    chk("t6_flush_req_valid", imem_req_valid, 1'b0);
    #4;
    chk_en = 0; reset = 1'b0; rq.delete();
    #1 check_reset_outputs("t6_reset");
    model_reset();
    cyc(0, 1, 0, 32'h0);
    reset = 1'b1; chk_en = 1;
    f = fire_log.size(); d = dlog.size();
    lat = 1;
    repeat (10) cyc(1, 1, 0, 32'h0);
    chk_fire("t6_restart_addr", f, 32'h0);
    chk_dlv("t6_restart_inst", d, 32'h0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
